// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Brief    : Data-memory responder with valid/ready request and response
//            channels, fixed access latency and an internal word array.
// Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              req_optype,
    input  logic              req_sext,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam logic [1:0] c_stIdle    = 2'd0;
    localparam logic [1:0] c_stWait    = 2'd1;
    localparam logic [1:0] c_stResp    = 2'd2;
    localparam logic [3:0] c_waitCount = 4'(WAIT_CYCLES);
    localparam int         c_depth     = 1 << ADDR_W;

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic [3:0]        r_count;
    logic              r_write;
    logic              r_optype;
    logic              r_sext;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_respData;
    logic              r_respErr;
    logic [31:0]       r_mem [c_depth];

    logic              w_accept;
    logic              w_doAccess;
    logic              w_opWrite;
    logic              w_opByte;
    logic              w_opSext;
    logic [ADDR_W+1:0] w_opAddr;
    logic [31:0]       w_opWdata;
    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_offset;
    logic              w_misaligned;
    logic [31:0]       w_memWord;
    logic [31:0]       w_storeWord;
    logic [31:0]       w_loadData;
    logic [7:0]        w_lane;

    assign req_ready  = (r_state == c_stIdle) && rst;
    assign resp_valid = (r_state == c_stResp);
    assign resp_rdata = r_respData;
    assign resp_err   = r_respErr;
    assign w_accept   = req_valid && req_ready;

    // A zero-latency access happens on the acceptance edge, before the
    // request is latched, so operands come straight from the port in IDLE.
    assign w_opWrite = (r_state == c_stIdle) ? req_write  : r_write;
    assign w_opByte  = (r_state == c_stIdle) ? req_optype : r_optype;
    assign w_opSext  = (r_state == c_stIdle) ? req_sext   : r_sext;
    assign w_opAddr  = (r_state == c_stIdle) ? req_addr   : r_addr;
    assign w_opWdata = (r_state == c_stIdle) ? req_wdata  : r_wdata;

    assign w_idx        = w_opAddr[ADDR_W+1:2];
    assign w_offset     = w_opAddr[1:0];
    assign w_misaligned = !w_opByte && (w_offset != 2'b00);
    assign w_memWord    = r_mem[w_idx];

    assign w_doAccess = rst &&
                        ((w_accept && (c_waitCount == 4'd0)) ||
                         ((r_state == c_stWait) && (r_count == 4'd1)));

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_stIdle: begin
                if (w_accept) begin
                    w_nextState = (c_waitCount == 4'd0) ? c_stResp : c_stWait;
                end
            end
            c_stWait: begin
                if (r_count == 4'd1) begin
                    w_nextState = c_stResp;
                end
            end
            c_stResp: begin
                if (resp_ready) begin
                    w_nextState = c_stIdle;
                end
            end
            default: w_nextState = c_stIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_stIdle;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Byte stores merge into the current word so the other lanes survive.
    always_comb begin
        w_storeWord = w_memWord;
        if (!w_opByte) begin
            w_storeWord = w_opWdata;
        end else begin
            case (w_offset)
                2'd0:    w_storeWord[7:0]   = w_opWdata[7:0];
                2'd1:    w_storeWord[15:8]  = w_opWdata[7:0];
                2'd2:    w_storeWord[23:16] = w_opWdata[7:0];
                default: w_storeWord[31:24] = w_opWdata[7:0];
            endcase
        end
    end

    assign w_lane     = w_memWord[{w_offset, 3'b000} +: 8];
    assign w_loadData = !w_opByte ? w_memWord :
                        (w_opSext ? {{24{w_lane[7]}}, w_lane} : {24'd0, w_lane});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= 4'd0;
            r_write    <= 1'b0;
            r_optype   <= 1'b0;
            r_sext     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_respData <= 32'd0;
            r_respErr  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_optype <= req_optype;
                r_sext   <= req_sext;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_count  <= c_waitCount;
            end else if (r_state == c_stWait) begin
                r_count <= r_count - 4'd1;
            end
            if (w_doAccess) begin
                r_respData <= (w_opWrite || w_misaligned) ? 32'd0 : w_loadData;
                r_respErr  <= w_misaligned;
            end
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_doAccess && w_opWrite && !w_misaligned) begin
            r_mem[w_idx] <= w_storeWord;
        end
    end

endmodule
`default_nettype wire

// File: doc/dm_responder.md
# dm_responder

Multi-cycle data-memory responder answering the load/store requests issued by the CPU datapath's memory stage. It replaces the zero-latency data memory with a valid/ready request channel and a valid/ready response channel, a configurable access latency and an internal 4 KB word array. Word and byte accesses are supported; byte loads are sign- or zero-extended.

## Interface
- ADDR_W, 10, word-address width; array depth is 2^ADDR_W words.
- WAIT_CYCLES, 2, access latency in cycles (0..15).

- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE with rst high.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W+2  byte address; [ADDR_W+1:2] = word index, [1:0] = byte offset.
- req_wdata  input  32  store data; byte stores use [7:0].
- req_optype  input  1  0 = word, 1 = byte (MemOpType encoding).
- req_sext  input  1  byte loads: 1 = sign-extend, 0 = zero-extend (MemDataExtType encoding).
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  misaligned word access.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata/optype/sext; counter := WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else perform the access on this edge and go to RESP.
- WAIT: counter decrements each cycle; on the edge where counter==1, perform the access, register results, go to RESP.
- RESP: resp_valid=1; resp_rdata/resp_err held stable. On resp_valid&resp_ready, go to IDLE and clear resp_valid.
- Access rules:
  - Word (optype=0), offset!=0: resp_err=1, resp_rdata=0, no array write.
  - Word load: resp_rdata = mem[idx]. Word store: mem[idx] := wdata.
  - Byte lanes little-endian: offset k selects bits [8k+7:8k].
  - Byte store: only the selected lane written; other three lanes unchanged.
  - Byte load: lane extended to 32 bits per latched sext.
  - Stores return resp_rdata=0, resp_err=0.
- Array contents are not reset; they are undefined until written.
- One transaction outstanding at a time; req_ready=0 in WAIT and RESP.

## Timing
- Reset (rst low at an edge): state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0. req_ready is 0 while rst is low.
- Reset in WAIT before the access edge aborts the transaction; no array write occurs and no response is produced. Reset in RESP drops the pending response.
- Acceptance edge E0. Access and store commit occur at edge E0+WAIT_CYCLES. resp_valid is high from the cycle after that edge.
- With WAIT_CYCLES=0, access and acceptance share E0, and resp_valid is high in the cycle after E0.
- Response handshake at edge E1 gives req_ready=1 in the cycle after E1.
- Minimum transaction period is WAIT_CYCLES+2 cycles, with resp_ready tied high.
- resp_ready low holds RESP indefinitely; outputs must not change while stalled.
- Request inputs are ignored outside IDLE. A later load observes every earlier committed store.
- Counter wraps never: it is loaded only in IDLE and stops at the transition to RESP.

## Test plan
- Word round trip, WAIT_CYCLES=2: store 0xDEADBEEF at addr 0x010, then load 0x010. Required: resp_valid 3 cycles after each acceptance, load returns 0xDEADBEEF, resp_err=0.
- Byte store lane: word 0x11223344 at 0x020, then byte store 0xAA at 0x022. Required: word load of 0x020 returns 0x11AA3344.
- Byte load extension: word 0x000080F0 at 0x030. Byte load 0x030 with sext=1 returns 0xFFFFFFF0. Byte load 0x031 with sext=0 returns 0x00000080. Byte load 0x032 with sext=1 returns 0x00000000.
- Misaligned: word store 0x12345678 at 0x041. Required: resp_err=1, resp_rdata=0. A subsequent word load of 0x040 returns the previous contents unchanged.
- Backpressure: load with resp_ready=0 for 5 cycles. Required: resp_valid stays 1, data constant, req_ready=0 throughout. IDLE resumes the cycle after resp_ready=1.
- Reset mid-WAIT: store 0xCAFEF00D to 0x050 (prior value 0x0), with rst low one cycle after acceptance. Required: all outputs reset next cycle, no response, load of 0x050 returns 0x0. Also repeat the word round trip with WAIT_CYCLES=0: response in the cycle after acceptance.
